// File: rtl/pressure_link_pkg.sv
// Shared definitions for the pressure sample serial link: frame layout,
// line levels, transmitter states and the parity rule.
package pressure_link_pkg;

    localparam int unsigned PRESSURE_W = 6;
    localparam int unsigned FRAME_BITS = 9;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic calc_parity(input logic [PRESSURE_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/pressure_frame_tx_bit_timer.sv
// Bit-time divider: tick is high on the last cycle of each CLKS_PER_BIT window.
// restart holds the window at its first cycle so a new frame starts aligned.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // With CLKS_PER_BIT=1 CNT_LAST is 0, so tick is permanently high.
    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pressure_frame_tx.sv
// Framed serial transmitter for pressure samples: start, data LSB-first,
// parity, stop. One sample accepted per valid/ready handshake in IDLE.
module pressure_frame_tx
    import pressure_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_W       = PRESSURE_W,
    parameter logic        PARITY_ODD   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pressureData,
    input  logic              dataValid,
    output logic              dataReady,
    output logic              txSerial,
    output logic              txBusy,
    output logic              frameDone
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_W);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_W - 1);

    tx_state_t             state_q,   state_d;
    logic [DATA_W-1:0]     shift_q,   shift_d;
    logic                  parity_q,  parity_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  tx_q,      tx_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  tick_c;
    logic                  restart_c;

    assign dataReady = (state_q == IDLE);
    assign txSerial  = tx_q;
    assign txBusy    = busy_q;
    assign frameDone = done_q;

    // The timer idles at its first cycle until the frame starts.
    assign restart_c = (state_q == IDLE);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_c),
        .tick    (tick_c)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dataValid) begin
                    shift_d   = pressureData;
                    parity_d  = calc_parity(pressureData, PARITY_ODD);
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick_c) state_d = DATA;
            end
            DATA: begin
                if (tick_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
                    end
                end
            end
            PARITY: begin
                if (tick_c) state_d = STOP;
            end
            STOP: begin
                if (tick_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the next state so it is registered.
        unique case (state_d)
            START:   tx_d = START_LVL;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = STOP_LVL;
            default: tx_d = LINE_IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule
